serial_mode_scheduler: RTL and testbench
========================================

Name: serial_mode_scheduler

Overview:
Sequencer for the serial-mode convolution engine (top_serial_mode). It sweeps a 2-D window of output positions over a feature map held in memory. For each position it drives the engine's feature base address and enable, then waits for the done pulse. It captures each 8-bit result and writes it into a linear result buffer. It sits between the host/config logic and the serial engine, replacing the hand-sequenced address stepping used at bring-up.

Parameters:
ADDR_W, 8, width of feature base address and result buffer address
DATA_W, 8, width of engine result
DIM_W, 4, width of output-map width/height and feature-map width fields
TIMEOUT, 255, max cycles in RUN without eng_done before the error abort (1..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
start  input  1  pulse; launches a sweep when IDLE
abort  input  1  synchronous abort of a sweep in progress
cfg_base  input  ADDR_W  feature address of output position (0,0)
cfg_fm_w  input  DIM_W  feature-map row pitch
cfg_out_w  input  DIM_W  output positions per row
cfg_out_h  input  DIM_W  output rows
eng_en  output  1  enable to serial engine
eng_baseaddr  output  ADDR_W  feature base address to engine
eng_done  input  1  engine is_done_o
eng_out  input  DATA_W  engine result
wr_en  output  1  result buffer write strobe
wr_addr  output  ADDR_W  result buffer index
wr_data  output  DATA_W  result value
busy  output  1  high whenever state != IDLE
done_o  output  1  one-cycle pulse at sweep end
err_timeout  output  1  sticky; set on engine timeout, cleared by next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0: eng_en, eng_baseaddr, wr_en, wr_addr, wr_data, busy, done_o, err_timeout. row, col and the timeout counter are 0.
- States: IDLE, RUN, WRITE, DONE.
- IDLE: start=1 latches cfg_* into internal registers, sets row=col=0, clears err_timeout, and goes to RUN next cycle.
  - If the latched cfg_out_w or cfg_out_h is 0, go to DONE instead; no writes occur.
  - cfg_* changes after acceptance have no effect on the current sweep.
- RUN: eng_en=1 and eng_baseaddr = base + row*fm_w + col, computed at full width and truncated mod 2^ADDR_W (wrap, no error).
  - The timeout counter increments every RUN cycle.
  - When eng_done=1 is sampled: register eng_out into wr_data, clear the counter, go to WRITE.
  - If the counter reaches TIMEOUT with eng_done=0: set err_timeout, go to DONE.
  - If eng_done=1 and the counter reaches TIMEOUT in the same cycle, done wins.
- WRITE (exactly one cycle): eng_en=0, wr_en=1, wr_addr = row*out_w + col (mod 2^ADDR_W).
  - Then advance: if col==out_w-1, col=0 and row=row+1; else col=col+1.
  - If the position just written was (out_h-1, out_w-1), go to DONE; else go to RUN.
- DONE (one cycle): done_o=1, eng_en=0, then go to IDLE.
- eng_baseaddr is registered and updates on entry to RUN. It holds its last value in the other states.
- eng_done outside RUN is ignored.
- start while busy=1 is ignored.
- abort=1 in any non-IDLE state goes to IDLE next cycle: no done_o, no wr_en, eng_en=0, err_timeout unchanged. abort in IDLE has no effect. If abort and a WRITE occur in the same cycle, the write still happens that cycle and the sweep then terminates.
- Latency:
  - start accepted at edge N gives busy=1 and eng_en=1 from N+1.
  - eng_done sampled at edge M gives wr_en=1 in cycle M+1, and eng_en re-asserts at M+2 with the new address.
  - Total sweep cycles = 1 + Σ(engine wait + 1) + 1.
- Reset mid-sweep returns to IDLE immediately and all outputs drop to 0.

Test Plan:
- cfg_base=9, fm_w=4, out_w=2, out_h=2, engine returns 0x11,0x22,0x33,0x44 after 5 cycles each -> eng_baseaddr sequence 9,10,13,14. Writes (0,0x11),(1,0x22),(2,0x33),(3,0x44). One done_o pulse, err_timeout=0.
- Engine done after 1 cycle, out_w=3, out_h=1, base=0, fm_w=8 -> addresses 0,1,2. eng_en drops for exactly one cycle between positions. wr_en high for 3 cycles total.
- Engine never asserts done, TIMEOUT=10 -> err_timeout=1 after 10 RUN cycles, done_o pulses, zero writes. A subsequent start clears err_timeout.
- base=0xFE, fm_w=4, out_w=2, out_h=2 -> addresses 0xFE,0xFF,0x02,0x03 (wrap).
- out_w=0 -> done_o one cycle after start, no eng_en, no wr_en. Also: start pulsed while busy -> ignored.
- abort asserted during the second RUN of a 2x2 sweep -> IDLE next cycle, no done_o, only 1 write. Also: rst=0 mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/serial_mode_scheduler.sv
// Sweeps a 2-D window of output positions across a feature map for the serial
// convolution engine and writes each result into a linear result buffer.
module serial_mode_scheduler #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int DIM_W   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [DIM_W-1:0]  cfg_fm_w,
   input  logic [DIM_W-1:0]  cfg_out_w,
   input  logic [DIM_W-1:0]  cfg_out_h,
   output logic              eng_en,
   output logic [ADDR_W-1:0] eng_baseaddr,
   input  logic              eng_done,
   input  logic [DATA_W-1:0] eng_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done_o,
   output logic              err_timeout
);
   localparam int PW = ADDR_W + 2*DIM_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DIM_W-1:0]  fm_w_q, fm_w_d;
   logic [DIM_W-1:0]  out_w_q, out_w_d;
   logic [DIM_W-1:0]  out_h_q, out_h_d;
   logic [DIM_W-1:0]  row_q, row_d;
   logic [DIM_W-1:0]  col_q, col_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] baseaddr_q, baseaddr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic [DIM_W-1:0]  row_nxt, col_nxt;
   logic              last_pos;
   logic [8:0]        cnt_inc;

   // base + r*pitch + c at full width, wrapped into the address space
   function automatic logic [ADDR_W-1:0] lin_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [DIM_W-1:0] r,
                                                  input logic [DIM_W-1:0] c,
                                                  input logic [DIM_W-1:0] pitch);
      return ADDR_W'(PW'(b) + PW'(r) * PW'(pitch) + PW'(c));
   endfunction

   always_comb begin
      last_pos = (row_q == out_h_q - DIM_W'(1)) && (col_q == out_w_q - DIM_W'(1));
      if (col_q == out_w_q - DIM_W'(1)) begin
         col_nxt = '0;
         row_nxt = row_q + DIM_W'(1);
      end else begin
         col_nxt = col_q + DIM_W'(1);
         row_nxt = row_q;
      end
      cnt_inc = {1'b0, cnt_q} + 9'd1;
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      fm_w_d     = fm_w_q;
      out_w_d    = out_w_q;
      out_h_d    = out_h_q;
      row_d      = row_q;
      col_d      = col_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      baseaddr_d = baseaddr_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = cfg_base;
               fm_w_d  = cfg_fm_w;
               out_w_d = cfg_out_w;
               out_h_d = cfg_out_h;
               row_d   = '0;
               col_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               if (cfg_out_w == '0 || cfg_out_h == '0) begin
                  state_d = S_DONE;
               end else begin
                  baseaddr_d = cfg_base;
                  state_d    = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (eng_done) begin
               // a done arriving on the timeout cycle still counts as success
               wr_data_d = eng_out;
               wr_addr_d = lin_addr('0, row_q, col_q, out_w_q);
               cnt_d     = '0;
               state_d   = S_WRITE;
            end else if (cnt_inc == 9'(TIMEOUT)) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_inc[7:0];
            end
         end
         S_WRITE: begin
            row_d = row_nxt;
            col_d = col_nxt;
            if (abort) begin
               state_d = S_IDLE;
            end else if (last_pos) begin
               state_d = S_DONE;
            end else begin
               baseaddr_d = lin_addr(base_q, row_nxt, col_nxt, fm_w_q);
               state_d    = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         fm_w_q     <= '0;
         out_w_q    <= '0;
         out_h_q    <= '0;
         row_q      <= '0;
         col_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         baseaddr_q <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         fm_w_q     <= fm_w_d;
         out_w_q    <= out_w_d;
         out_h_q    <= out_h_d;
         row_q      <= row_d;
         col_q      <= col_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         baseaddr_q <= baseaddr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // an abort landing on the DONE cycle suppresses the completion pulse
   assign eng_en       = (state_q == S_RUN);
   assign wr_en        = (state_q == S_WRITE);
   assign busy         = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE) && !abort;
   assign eng_baseaddr = baseaddr_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_serial_mode_scheduler.sv
// Scoreboard bench: stimulus pushes expected engine addresses, buffer writes and
// completions into queues; a monitor pops and compares as the DUT presents them.
module tb_serial_mode_scheduler;
   localparam int TMO = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] cfg_base = '0;
   logic [3:0] cfg_fm_w = '0;
   logic [3:0] cfg_out_w = '0;
   logic [3:0] cfg_out_h = '0;
   logic       eng_done = 1'b0;
   logic [7:0] eng_out = '0;
   logic       eng_en, wr_en, busy, done_o, err_timeout;
   logic [7:0] eng_baseaddr, wr_addr, wr_data;

   serial_mode_scheduler #(.ADDR_W(8), .DATA_W(8), .DIM_W(4), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_base(cfg_base), .cfg_fm_w(cfg_fm_w), .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h),
      .eng_en(eng_en), .eng_baseaddr(eng_baseaddr), .eng_done(eng_done), .eng_out(eng_out),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done_o(done_o), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {int lat; logic [7:0] data;} eng_t;

   int         checks = 0;
   int         errors = 0;
   int         wr_count = 0;
   int         done_count = 0;
   int         exp_addr_q[$];
   logic [15:0] exp_wr_q[$];
   logic       exp_done_q[$];
   eng_t       eng_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // engine model: answers lat cycles after eng_en rises (lat 0 = never answers)
   eng_t eng_cur;
   int   eng_wait = 0;
   bit   eng_active = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         eng_done = 1'b0;
         if (!rst || !eng_en) begin
            eng_active = 1'b0;
         end else begin
            if (!eng_active) begin
               if (eng_q.size() > 0) eng_cur = eng_q.pop_front();
               else eng_cur.lat = 0;
               eng_active = 1'b1;
               eng_wait   = 0;
            end
            eng_wait++;
            if (eng_wait == eng_cur.lat) begin
               eng_done   = 1'b1;
               eng_out    = eng_cur.data;
               eng_active = 1'b0;
            end
         end
      end
   end

   // monitor
   logic prev_en = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (eng_en && !prev_en) begin
            if (exp_addr_q.size() == 0) chk("addr_unexpected", {24'h0, eng_baseaddr}, 32'hFFFF_FFFF);
            else chk("eng_baseaddr", {24'h0, eng_baseaddr}, exp_addr_q.pop_front());
         end
         if (wr_en) begin
            wr_count++;
            if (exp_wr_q.size() == 0) chk("wr_unexpected", {16'h0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            else chk("wr_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, exp_wr_q.pop_front()});
         end
         if (done_o) begin
            done_count++;
            if (exp_done_q.size() == 0) chk("done_unexpected", {31'h0, err_timeout}, 32'hFFFF_FFFF);
            else chk("done_err", {31'h0, err_timeout}, {31'h0, exp_done_q.pop_front()});
         end
         prev_en = eng_en && rst;
      end
   end

   task automatic chk_drained(input string name);
      chk(name, exp_addr_q.size() + exp_wr_q.size() + exp_done_q.size(), 0);
      exp_addr_q.delete();
      exp_wr_q.delete();
      exp_done_q.delete();
      eng_q.delete();
   endtask

   task automatic pulse_start(input logic [7:0] b, input logic [3:0] fm, input logic [3:0] w,
                              input logic [3:0] h);
      @(negedge clk);
      cfg_base = b; cfg_fm_w = fm; cfg_out_w = w; cfg_out_h = h;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_base = 8'($urandom); cfg_fm_w = 4'($urandom);
      cfg_out_w = 4'($urandom); cfg_out_h = 4'($urandom);
      chk("busy_after_start", {31'h0, busy}, 32'd1);
      chk("err_cleared_on_start", {31'h0, err_timeout}, 32'd0);
   endtask

   // lat_fixed: 0 = random per position, -1 = engine never answers
   task automatic run_sweep(input logic [7:0] b, input logic [3:0] fm, input logic [3:0] w,
                            input logic [3:0] h, input int lat_fixed);
      int   exp_cycles, cyc, lat;
      eng_t e;
      bit   tmo;
      tmo = (lat_fixed < 0);
      exp_cycles = 2;
      if (w == 0 || h == 0) begin
         exp_done_q.push_back(1'b0);
      end else if (tmo) begin
         exp_addr_q.push_back(int'(b));
         e.lat = 0; e.data = '0;
         eng_q.push_back(e);
         exp_done_q.push_back(1'b1);
         exp_cycles = 1 + TMO + 1;
      end else begin
         for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
               lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, TMO));
               e.lat = lat; e.data = 8'($urandom);
               eng_q.push_back(e);
               exp_addr_q.push_back((int'(b) + r * int'(fm) + c) % 256);
               exp_wr_q.push_back({8'((r * int'(w) + c) % 256), e.data});
               exp_cycles += lat + 1;
            end
         end
         exp_done_q.push_back(1'b0);
      end
      pulse_start(b, fm, w, h);
      cyc = 2;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (!busy) break;
         cyc++;
         if (cyc == 3) begin
            start = 1'b1;
            cfg_out_w = 4'd1; cfg_out_h = 4'd1;
         end
      end
      start = 1'b0;
      chk("sweep_cycles", cyc, exp_cycles);
      chk("err_timeout_idle", {31'h0, err_timeout}, {31'h0, tmo});
      chk_drained("queues_drained");
   endtask

   initial begin
      int w0, d0;
      #1;
      chk("reset_outputs", {eng_en, eng_baseaddr, wr_en, wr_addr, wr_data, busy, done_o, err_timeout},
          '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_sweep(8'd9, 4'd4, 4'd2, 4'd2, 5);
      run_sweep(8'd0, 4'd8, 4'd3, 4'd1, 1);
      run_sweep(8'd7, 4'd3, 4'd1, 4'd1, TMO);
      run_sweep(8'd40, 4'd2, 4'd2, 4'd1, -1);
      run_sweep(8'hFE, 4'd4, 4'd2, 4'd2, 0);
      run_sweep(8'd5, 4'd3, 4'd0, 4'd2, 0);
      run_sweep(8'd5, 4'd3, 4'd3, 4'd0, 0);

      // abort during the second RUN of a 2x2 sweep
      for (int i = 0; i < 4; i++) begin
         eng_t e;
         e.lat = 5; e.data = 8'(8'hA0 + i);
         eng_q.push_back(e);
      end
      exp_addr_q.push_back(20);
      exp_addr_q.push_back(21);
      exp_wr_q.push_back({8'd0, 8'hA0});
      w0 = wr_count; d0 = done_count;
      pulse_start(8'd20, 4'd5, 4'd2, 4'd2);
      for (int k = 0; k < 200 && wr_count == w0; k++) @(negedge clk);
      for (int k = 0; k < 200 && !eng_en; k++) @(negedge clk);
      chk("abort_reached_run2", {31'h0, eng_en}, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", {29'h0, busy, eng_en, done_o}, 32'd0);
      repeat (20) @(negedge clk);
      chk("abort_writes", wr_count - w0, 1);
      chk("abort_no_done", done_count - d0, 0);
      chk_drained("abort_drained");

      // asynchronous reset while the engine is working
      exp_addr_q.push_back(3);
      begin
         eng_t e;
         e.lat = 8; e.data = 8'h5A;
         eng_q.push_back(e);
      end
      pulse_start(8'd3, 4'd2, 4'd2, 4'd2);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_outputs",
          {eng_en, eng_baseaddr, wr_en, wr_addr, wr_data, busy, done_o, err_timeout}, '0);
      @(negedge clk);
      rst = 1'b1;
      chk_drained("reset_drained");

      for (int i = 0; i < 10; i++) begin
         run_sweep(8'($urandom), 4'($urandom), 4'($urandom_range(1, 4)),
                   4'($urandom_range(1, 3)), 0);
      end
      run_sweep(8'd100, 4'd3, 4'd2, 4'd2, -1);
      run_sweep(8'd1, 4'd15, 4'd2, 4'd3, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
